// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_det_pkg;

    // FILL: still collecting the first W-1 bits of a window; ARMED: every en bit completes a window.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int DEF_W     = 4;
    localparam int DEF_CNT_W = 8;

endpackage : seq_det_pkg

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, synchronous clear wins over inc.
// Latency: q reflects an inc or clr on the next rising edge of clk.
// Backpressure: none; one increment per cycle at most.
// Ports: clk, reset (async active-high), clr (sync clear), inc (count enable), q (count value).
module sat_counter #(
    parameter int CNT_W = seq_det_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: flags every W-bit window equal to PATTERN (MSB received first) and counts matches.
// Latency: p pulses one clk after the en cycle carrying the last bit of a match.
// Backpressure: none; en=0 simply freezes history, fill, state and count.
// Ports: clk, reset (async active-high), clr (sync clear), en (din valid), din (serial bit),
//        p (one-cycle match pulse), match_cnt (saturating match count), armed (window complete on next en bit).
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int             W       = DEF_W,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic             p,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int             FW        = $clog2(W);
    // Fill value at which the next en bit leaves W-1 valid bits behind it.
    localparam logic [FW-1:0]  FILL_LAST = FW'(W - 2);

    logic [W-1:0]  history_q, history_d;
    logic [FW-1:0] fill_q, fill_d;
    state_t        state_q, state_d;
    logic          p_q;
    logic          match;
    logic [W-1:0]  window;

    // The oldest history bit has always aged out of the compare window; it is kept so the
    // register holds the full W-bit history but feeds no logic.
    logic unused_hist_msb;
    assign unused_hist_msb = history_q[W-1];

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        state_d   = state_q;
        match     = 1'b0;
        window    = {history_q[W-2:0], din};

        if (clr) begin
            // clr beats en: the din offered alongside it is dropped.
            history_d = '0;
            fill_d    = '0;
            state_d   = FILL;
        end else if (en) begin
            history_d = window;
            case (state_q)
                FILL: begin
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FILL_LAST) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (window == PATTERN) begin
                        match = 1'b1;
                        if (OVERLAP == 0) begin
                            // Restart filling so the matched bits age out before the next compare.
                            fill_d  = '0;
                            state_d = FILL;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history_q <= '0;
            fill_q    <= '0;
            state_q   <= FILL;
            p_q       <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            p_q       <= match;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (match),
        .q     (match_cnt)
    );

    assign p     = p_q;
    assign armed = (state_q == ARMED);

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic reset, clr, en, din;

    logic       p_a, armed_a;
    logic [7:0] cnt_a;
    logic       p_b, armed_b;
    logic [7:0] cnt_b;
    logic       p_c, armed_c;
    logic [1:0] cnt_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .din(din),
        .p(p_a), .match_cnt(cnt_a), .armed(armed_a));

    seq_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .din(din),
        .p(p_b), .match_cnt(cnt_b), .armed(armed_b));

    seq_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .din(din),
        .p(p_c), .match_cnt(cnt_c), .armed(armed_c));

    typedef struct {
        logic clr;
        logic en;
        logic din;
        logic pa;
        int   ca;
        logic aa;
        logic pb;
        int   cb;
        logic ab;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after an edge, let the next edge capture them, sample 1 time unit later.
    task automatic step(input logic c, input logic e, input logic d);
        clr = c;
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s;
        int          m;
        int          exp_c;

        // Stream 1,0,1,1,0,1,1 then a held cycle, then clr with en, then one fresh bit.
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};

        reset = 1'b1;
        clr   = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_p",     int'(p_a),     0);
        chk("reset_armed", int'(armed_a), 0);
        chk("reset_cnt",   int'(cnt_a),   0);
        reset = 1'b0;

        // Table: OVERLAP=1 (a) and OVERLAP=0 (b) side by side on the same stream.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].clr, tbl[i].en, tbl[i].din);
            chk($sformatf("tbl%0d_p_a", i),     int'(p_a),     int'(tbl[i].pa));
            chk($sformatf("tbl%0d_cnt_a", i),   int'(cnt_a),   tbl[i].ca);
            chk($sformatf("tbl%0d_armed_a", i), int'(armed_a), int'(tbl[i].aa));
            chk($sformatf("tbl%0d_p_b", i),     int'(p_b),     int'(tbl[i].pb));
            chk($sformatf("tbl%0d_cnt_b", i),   int'(cnt_b),   tbl[i].cb);
            chk($sformatf("tbl%0d_armed_b", i), int'(armed_b), int'(tbl[i].ab));
        end

        // Hold: 1,0,1 then three en=0 cycles with din=1, then the final 1.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("hold%0d_p_a", i),     int'(p_a),     0);
            chk($sformatf("hold%0d_armed_a", i), int'(armed_a), 1);
        end
        step(1'b0, 1'b1, 1'b1);
        chk("hold_final_p_a",   int'(p_a),   1);
        chk("hold_final_cnt_a", int'(cnt_a), 1);
        chk("hold_final_p_b",   int'(p_b),   1);
        step(1'b0, 1'b0, 1'b0);
        chk("hold_pulse_width", int'(p_a),   0);

        // Mid-stream reset: partial 1,0,1 is abandoned; reset acts without a clock edge.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_armed", int'(armed_a), 0);
        chk("async_rst_cnt",   int'(cnt_a),   0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        chk("rst_b1_p", int'(p_a), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("rst_b2_p", int'(p_a), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_b3_p",     int'(p_a),     0);
        chk("rst_b3_armed", int'(armed_a), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_b4_p",   int'(p_a),   1);
        chk("rst_b4_cnt", int'(cnt_a), 1);

        // clr together with the completing bit: no pulse and everything cleared.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_en_p",     int'(p_a),     0);
        chk("clr_en_cnt",   int'(cnt_a),   0);
        chk("clr_en_armed", int'(armed_a), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("post_clr_p",     int'(p_a),     0);
        chk("post_clr_armed", int'(armed_a), 0);

        // Saturation on the 2-bit counter: 5 overlapping matches, count stops at 3.
        step(1'b1, 1'b0, 1'b0);
        s = 16'b1011011011011011;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, s[15-i]);
            if (i > 0 && (i % 3) == 0) m++;
            exp_c = (m > 3) ? 3 : m;
            chk($sformatf("sat%0d_cnt_c", i), int'(cnt_c), exp_c);
            chk($sformatf("sat%0d_p_c", i),   int'(p_c),   (i > 0 && (i % 3) == 0) ? 1 : 0);
        end
        chk("sat_final_cnt_a", int'(cnt_a), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_seq_pattern_detector
